// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer and its helpers.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } match_state_t;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;

    localparam logic [9:0] DEF_LEFT_X   = 10'd20;
    localparam logic [9:0] DEF_RIGHT_X  = 10'd769;
    localparam logic [9:0] DEF_CENTER_X = 10'd395;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// A held button yields exactly one rise strobe, three clocks after its edge.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise_d  = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer for the pong engine: serve countdown, miss detection from the
// ball x position, score keeping and winner declaration.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int         SERVE_CYCLES = 50_000_000,
    parameter int         WIN_SCORE    = 7,
    parameter int         SCORE_W      = 4,
    parameter logic [9:0] LEFT_X       = DEF_LEFT_X,
    parameter logic [9:0] RIGHT_X      = DEF_RIGHT_X,
    parameter logic [9:0] CENTER_X     = DEF_CENTER_X
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [9:0]         x_ball_pos,
    output logic               core_reset,
    output logic [SCORE_W-1:0] l_score,
    output logic [SCORE_W-1:0] r_score,
    output logic               point_pulse,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int                 CNT_W      = $clog2(SERVE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    logic start_rise;

    btn_edge_sync u_start_sync (
        .clk  (clk),
        .rst  (reset),
        .btn  (start),
        .rise (start_rise)
    );

    match_state_t       state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [SCORE_W-1:0] l_score_q,    l_score_d;
    logic [SCORE_W-1:0] r_score_q,    r_score_d;
    logic [1:0]         winner_q,     winner_d;
    logic               point_q,      point_d;
    logic               core_reset_q, core_reset_d;
    logic [9:0]         x_prev_q,     x_prev_d;

    logic left_miss;
    logic right_miss;

    // A miss is the engine re-centring the ball straight from a paddle face;
    // a bounce only moves one pixel, so it can never match.
    assign left_miss  = (x_prev_q == LEFT_X)  && (x_ball_pos == CENTER_X);
    assign right_miss = (x_prev_q == RIGHT_X) && (x_ball_pos == CENTER_X);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        winner_d  = winner_q;
        point_d   = 1'b0;
        x_prev_d  = x_ball_pos;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    l_score_d = '0;
                    r_score_d = '0;
                    winner_d  = WINNER_NONE;
                    cnt_d     = '0;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                x_prev_d = CENTER_X;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == SERVE_LAST) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (left_miss) begin
                    r_score_d = (r_score_q >= WIN_VAL) ? WIN_VAL : r_score_q + SCORE_ONE;
                    point_d   = 1'b1;
                    state_d   = ST_POINT;
                end else if (right_miss) begin
                    l_score_d = (l_score_q >= WIN_VAL) ? WIN_VAL : l_score_q + SCORE_ONE;
                    point_d   = 1'b1;
                    state_d   = ST_POINT;
                end
            end
            ST_POINT: begin
                // Scores were updated on entry, so they already include this point.
                if (l_score_q == WIN_VAL) begin
                    winner_d = WINNER_LEFT;
                    state_d  = ST_OVER;
                end else if (r_score_q == WIN_VAL) begin
                    winner_d = WINNER_RIGHT;
                    state_d  = ST_OVER;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        core_reset_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            l_score_q    <= '0;
            r_score_q    <= '0;
            winner_q     <= WINNER_NONE;
            point_q      <= 1'b0;
            core_reset_q <= 1'b1;
            x_prev_q     <= CENTER_X;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            l_score_q    <= l_score_d;
            r_score_q    <= r_score_d;
            winner_q     <= winner_d;
            point_q      <= point_d;
            core_reset_q <= core_reset_d;
            x_prev_q     <= x_prev_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign l_score     = l_score_q;
    assign r_score     = r_score_q;
    assign point_pulse = point_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule
